// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop input synchroniser, free-running oversample
// tick generator and a start/data/stop FSM with mid-bit sampling.
module uart_rx #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_rxd,
  output logic [7:0] o_rx_data,
  output logic       o_done,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam int DIV    = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_LAST = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] FULL_LAST = TICK_W'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  state_t             state, state_nxt;
  logic               rxd_m, rxd_s;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic [TICK_W-1:0]  tick_cnt, tick_cnt_nxt;
  logic [2:0]         bit_idx, bit_idx_nxt;
  logic [7:0]         shreg, shreg_nxt;
  logic [7:0]         rx_data_nxt;
  logic               done_nxt, frame_err_nxt;

  // Bring the asynchronous pin into the clock domain; idles high out of reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rxd_m <= 1'b1;
      rxd_s <= 1'b1;
    end else begin
      rxd_m <= i_rxd;
      rxd_s <= rxd_m;
    end
  end

  // Free-running oversample divider; never realigned to the start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick   = (div_cnt == DIV_LAST);
  assign o_busy = (state != IDLE);

  // FSM state, counters and registered output strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_idx     <= '0;
      o_rx_data   <= 8'h00;
      o_done      <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      state       <= state_nxt;
      tick_cnt    <= tick_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      o_rx_data   <= rx_data_nxt;
      o_done      <= done_nxt;
      o_frame_err <= frame_err_nxt;
    end
  end

  // Shift register holds the byte under assembly; its content is irrelevant until a frame completes.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  // Next-state logic: start qualification at mid start bit, then one sample per bit period.
  always_comb begin
    state_nxt     = state;
    tick_cnt_nxt  = tick_cnt;
    bit_idx_nxt   = bit_idx;
    shreg_nxt     = shreg;
    rx_data_nxt   = o_rx_data;
    done_nxt      = 1'b0;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (!rxd_s) begin
          state_nxt    = START;
          tick_cnt_nxt = '0;
          bit_idx_nxt  = '0;
        end
      end
      START: begin
        if (tick) begin
          if (tick_cnt == HALF_LAST) begin
            tick_cnt_nxt = '0;
            // A line that is high again by mid start bit was only a glitch.
            state_nxt    = rxd_s ? IDLE : DATA;
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_nxt = '0;
            shreg_nxt    = {rxd_s, shreg[7:1]};
            bit_idx_nxt  = bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state_nxt = STOP;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (tick_cnt == FULL_LAST) begin
            tick_cnt_nxt = '0;
            if (rxd_s) begin
              rx_data_nxt = shreg;
              done_nxt    = 1'b1;
              state_nxt   = IDLE;
            end else begin
              // Hold off until the line recovers so a break reports only once.
              frame_err_nxt = 1'b1;
              state_nxt     = WAIT_IDLE;
            end
          end else begin
            tick_cnt_nxt = tick_cnt + 1'b1;
          end
        end
      end
      WAIT_IDLE: begin
        if (rxd_s) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
